shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//  Sequencer in front of the 3-bit-amount shift unit. Accepts one full 0..31-bit shift request,
//  splits it into passes of at most MAX_STEP bits, and drives the unit once per pass.
//  Each pass's result is fed back as the next pass's input; the final word goes back on a
//  valid/ready response port. Sits between the EX-stage issue logic and the shift unit.
// PARAMETERS
//  WIDTH    32  datapath width
//  MAX_STEP 7   largest shift per pass (unit takes a 3-bit amount)
//  SH_LAT   2   cycles en_sh must be held high, inputs stable, before sh_out is valid
// PORTS
//  clk2      in   1      clock, rising edge
//  rst2      in   1      reset, asynchronous, active-high
//  req_valid in   1      request present
//  req_ready out  1      controller can accept (high only in IDLE)
//  req_data  in   WIDTH  operand to shift
//  req_op    in   3      000 lsl, 001 asl, 010 lsr, 011 asr; others invalid
//  req_amt   in   5      total shift amount 0..31
//  rsp_valid out  1      result present
//  rsp_ready in   1      consumer takes result
//  rsp_data  out  WIDTH  shifted result
//  rsp_carry out  1      sh_carry captured on the final pass (0 if no pass was run)
//  rsp_err   out  1      invalid req_op; rsp_data = req_data
//  busy      out  1      state != IDLE
//  en_sh     out  1      shift unit enable
//  sh_in     out  WIDTH  shift unit operand
//  sh_amt    out  3      shift unit amount for this pass
//  sh_op     out  3      shift unit op (the latched req_op)
//  sh_out    in   WIDTH  shift unit result
//  sh_carry  in   1      shift unit carry
// BEHAVIOUR
//  Reset: all outputs 0 (req_ready 0 while rst2 high), state IDLE, counters 0; takes effect
//   immediately. Reset mid-operation drops en_sh at once and discards the request; no response.
//  FSM IDLE -> ISSUE -> CAPTURE -> (ISSUE | DONE) -> IDLE.
//  IDLE: req_ready=1. On req_valid&req_ready, latch data into work, op, and rem=req_amt.
//   Invalid op or amt==0: go DONE (rsp_data=req_data, rsp_carry=0, rsp_err=invalid).
//   Otherwise go ISSUE.
//  ISSUE: step=min(rem,MAX_STEP); en_sh=1; sh_in=work; sh_amt=step; sh_op=op.
//   All four are held constant for exactly SH_LAT cycles (lat counter), then go CAPTURE.
//  CAPTURE: en_sh=0. At the clock edge, work<=sh_out, carry<=sh_carry, rem<=rem-step.
//   If the new rem is 0 go DONE, else go ISSUE.
//  DONE: rsp_valid=1; rsp_data/rsp_carry/rsp_err are stable until rsp_ready.
//   On handshake go IDLE. No new request is accepted in the same cycle.
//  Passes = ceil(amt/MAX_STEP) (31 -> 7,7,7,7,3). rsp_valid is first high
//   passes*(SH_LAT+1)+1 cycles after the accept edge; 1 cycle when amt=0 or op invalid.
//  asr sign fill is correct across passes because each pass preserves bit WIDTH-1.
//  en_sh is never high outside ISSUE; sh_* outputs are 0 in IDLE.
// TESTING (bench models the unit as an ideal shifter with SH_LAT-cycle latency)
//  lsl 0x00000001 amt 31 -> rsp_data 0x80000000; 5 passes, en_sh high 10 cycles, rsp at +16
//  asr 0x80000000 amt 20 -> 0xFFFFF800; sh_amt sequence 7,7,6; rsp_valid at +10
//  amt 0, data 0x1234ABCD -> rsp_data 0x1234ABCD at +1; en_sh never asserted; rsp_carry 0
//  op 3'b100 -> rsp_err=1, data unchanged, no en_sh; rsp_ready low 5 cycles -> outputs stable, req_ready 0
//  rst2 pulsed during pass 2 of lsr amt 14 -> en_sh/busy 0 same cycle; next lsr 0xF0000000 amt 4 -> 0x0F000000
//  back-to-back requests with rsp_ready tied 1 -> second accepted the cycle after first response

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Multi-pass sequencer for a 3-bit-amount shift unit: splits a 0..31-bit shift into
// passes of at most MAX_STEP bits, feeding each pass's result into the next.
module shift_seq_ctrl #(
    parameter int WIDTH    = 32,
    parameter int MAX_STEP = 7,
    parameter int SH_LAT   = 2
) (
    input  logic             clk2,
    input  logic             rst2,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [2:0]       req_op,
    input  logic [4:0]       req_amt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic             busy,
    output logic             en_sh,
    output logic [WIDTH-1:0] sh_in,
    output logic [2:0]       sh_amt,
    output logic [2:0]       sh_op,
    input  logic [WIDTH-1:0] sh_out,
    input  logic             sh_carry
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    localparam logic [4:0] MAX_AMT  = 5'(MAX_STEP);
    localparam logic [7:0] LAT_LAST = 8'(SH_LAT - 1);

    state_t     state;
    logic [4:0] rem;
    logic [7:0] lat;
    logic [4:0] rem_next;
    logic       accept;
    logic       bad_op;

    function automatic logic [2:0] pass_amt(input logic [4:0] r);
        return (r > MAX_AMT) ? MAX_AMT[2:0] : r[2:0];
    endfunction

    // sh_in doubles as the working word and sh_amt as the current pass length
    always_comb begin
        rem_next = rem - {2'b00, sh_amt};
        accept   = req_valid & req_ready;
        bad_op   = req_op[2];
    end

    always_ff @(posedge clk2 or posedge rst2) begin
        if (rst2) begin
            state     <= IDLE;
            rem       <= '0;
            lat       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            en_sh     <= 1'b0;
            sh_in     <= '0;
            sh_amt    <= '0;
            sh_op     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (bad_op || req_amt == '0) begin
                            state     <= DONE;
                            rem       <= '0;
                            rsp_valid <= 1'b1;
                            rsp_data  <= req_data;
                            rsp_carry <= 1'b0;
                            rsp_err   <= bad_op;
                        end else begin
                            state  <= ISSUE;
                            rem    <= req_amt;
                            lat    <= '0;
                            en_sh  <= 1'b1;
                            sh_in  <= req_data;
                            sh_amt <= pass_amt(req_amt);
                            sh_op  <= req_op;
                        end
                    end
                end
                ISSUE: begin
                    if (lat == LAT_LAST) begin
                        en_sh <= 1'b0;
                        state <= CAPTURE;
                    end else begin
                        lat <= lat + 8'd1;
                    end
                end
                CAPTURE: begin
                    rem <= rem_next;
                    if (rem_next == '0) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= sh_out;
                        rsp_carry <= sh_carry;
                        rsp_err   <= 1'b0;
                        sh_in     <= '0;
                        sh_amt    <= '0;
                        sh_op     <= '0;
                    end else begin
                        state  <= ISSUE;
                        lat    <= '0;
                        en_sh  <= 1'b1;
                        sh_in  <= sh_out;
                        sh_amt <= pass_amt(rem_next);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_data  <= '0;
                        rsp_carry <= 1'b0;
                        rsp_err   <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl with an ideal SH_LAT-latency shift unit model
// and a whole-shift reference model.
module tb_shift_seq_ctrl;

    localparam int W  = 32;
    localparam int MS = 7;
    localparam int SL = 2;

    logic         clk2 = 1'b0;
    logic         rst2 = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_data = '0;
    logic [2:0]   req_op = '0;
    logic [4:0]   req_amt = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic         rsp_carry;
    logic         rsp_err;
    logic         busy;
    logic         en_sh;
    logic [W-1:0] sh_in;
    logic [2:0]   sh_amt;
    logic [2:0]   sh_op;
    logic [W-1:0] sh_out = '0;
    logic         sh_carry = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    shift_seq_ctrl #(.WIDTH(W), .MAX_STEP(MS), .SH_LAT(SL)) dut (
        .clk2(clk2), .rst2(rst2),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_op(req_op), .req_amt(req_amt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_err(rsp_err), .busy(busy),
        .en_sh(en_sh), .sh_in(sh_in), .sh_amt(sh_amt), .sh_op(sh_op),
        .sh_out(sh_out), .sh_carry(sh_carry)
    );

    always #5 clk2 = ~clk2;

    // {carry, result} of shifting d by amt bits in one go
    function automatic logic [W:0] ideal(input logic [W-1:0] d, input logic [2:0] op, input int amt);
        logic [W-1:0] r;
        logic         c;
        if (amt == 0 || op[2]) return {1'b0, d};
        case (op[1:0])
            2'b00, 2'b01: begin r = d << amt; c = d[W-amt]; end
            2'b10:        begin r = d >> amt; c = d[amt-1]; end
            default:      begin r = $unsigned($signed(d) >>> amt); c = d[amt-1]; end
        endcase
        return {c, r};
    endfunction

    // Shift unit: output is junk until en_sh has been held SL cycles
    int           ucnt = 0;
    int           stab_viol = 0;
    logic [W-1:0] p_in;
    logic [2:0]   p_amt, p_op;
    always @(posedge clk2) begin
        if (en_sh) begin
            if (ucnt > 0 && (sh_in !== p_in || sh_amt !== p_amt || sh_op !== p_op)) stab_viol++;
            p_in  <= sh_in;
            p_amt <= sh_amt;
            p_op  <= sh_op;
            if (ucnt + 1 == SL) {sh_carry, sh_out} <= ideal(sh_in, sh_op, int'(sh_amt));
            else if (ucnt == 0) begin sh_out <= $urandom; sh_carry <= ~sh_carry; end
            ucnt <= ucnt + 1;
        end else begin
            ucnt <= 0;
        end
    end

    int         viol = 0;
    int         en_cycles = 0;
    logic       mon_on = 1'b0;
    logic       prev_en = 1'b0;
    logic [2:0] amt_seq[$];
    always @(negedge clk2) begin
        if (en_sh && !busy) viol++;
        if (!busy && (sh_in !== '0 || sh_amt !== '0 || sh_op !== '0)) viol++;
        if (mon_on && en_sh) begin
            en_cycles++;
            if (!prev_en) amt_seq.push_back(sh_amt);
        end
        prev_en = en_sh;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end

    // Issue one request and return at the negedge where rsp_valid is first seen
    task automatic do_req(input logic [W-1:0] d, input logic [2:0] op, input logic [4:0] amt,
                          output int lat, output logic ok);
        en_cycles = 0;
        amt_seq.delete();
        ok  = 1'b1;
        lat = 0;
        @(negedge clk2);
        req_valid = 1'b1; req_data = d; req_op = op; req_amt = amt; rsp_ready = 1'b0;
        for (int i = 0; i < 40 && !req_ready; i++) @(negedge clk2);
        if (!req_ready) begin ok = 1'b0; req_valid = 1'b0; return; end
        @(posedge clk2);
        mon_on = 1'b1;
        while (lat < 200) begin
            @(negedge clk2);
            lat++;
            if (lat == 1) begin
                req_valid = 1'b0; req_data = $urandom; req_op = 3'($urandom); req_amt = 5'($urandom);
            end
            if (rsp_valid) break;
        end
        mon_on = 1'b0;
        if (!rsp_valid) ok = 1'b0;
    endtask

    task automatic finish_rsp;
        rsp_ready = 1'b1;
        @(negedge clk2);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst2 = 1'b1;
        #2;
        n_cmp++;
        if ({req_ready, rsp_valid, busy, en_sh, rsp_err, rsp_carry} !== 6'b0 || rsp_data !== '0) begin
            n_bad++;
            $display("FAIL reset_ctl got=%b data=%h need 000000/0", {req_ready, rsp_valid, busy, en_sh, rsp_err, rsp_carry}, rsp_data);
        end
        @(negedge clk2);
        n_cmp++;
        if (req_ready !== 1'b0 || sh_in !== '0 || sh_amt !== '0 || sh_op !== '0) begin
            n_bad++;
            $display("FAIL reset_sh ready=%b sh_in=%h amt=%0d op=%0d need all 0", req_ready, sh_in, sh_amt, sh_op);
        end
        rst2 = 1'b0;
        @(negedge clk2);
        n_cmp++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle ready=%b busy=%b need 1/0", req_ready, busy);
        end
    endtask

    task automatic test_lsl31;
        int lat; logic ok;
        do_req(32'h0000_0001, 3'b000, 5'd31, lat, ok);
        n_cmp++;
        if (ok !== 1'b1 || rsp_data !== 32'h8000_0000 || rsp_carry !== 1'b0) begin
            n_bad++;
            $display("FAIL lsl31_data ok=%b got=%h c=%b need 80000000 c=0", ok, rsp_data, rsp_carry);
        end
        n_cmp++;
        if (lat !== 16 || en_cycles !== 10 || amt_seq.size() !== 5) begin
            n_bad++;
            $display("FAIL lsl31_timing lat=%0d en=%0d passes=%0d need 16/10/5", lat, en_cycles, amt_seq.size());
        end
        finish_rsp();
    endtask

    task automatic test_asr20;
        int lat; logic ok; logic [8:0] seq;
        do_req(32'h8000_0000, 3'b011, 5'd20, lat, ok);
        seq = (amt_seq.size() == 3) ? {amt_seq[0], amt_seq[1], amt_seq[2]} : 9'h1FF;
        n_cmp++;
        if (ok !== 1'b1 || rsp_data !== 32'hFFFF_F800) begin
            n_bad++;
            $display("FAIL asr20_data got=%h need fffff800", rsp_data);
        end
        n_cmp++;
        if (seq !== {3'd7, 3'd7, 3'd6} || lat !== 10) begin
            n_bad++;
            $display("FAIL asr20_seq seq=%o lat=%0d need 776/10", seq, lat);
        end
        finish_rsp();
    endtask

    task automatic test_amt0;
        int lat; logic ok;
        do_req(32'h1234_ABCD, 3'b000, 5'd0, lat, ok);
        n_cmp++;
        if (ok !== 1'b1 || rsp_data !== 32'h1234_ABCD || rsp_carry !== 1'b0 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL amt0_data got=%h c=%b e=%b need 1234abcd 0 0", rsp_data, rsp_carry, rsp_err);
        end
        n_cmp++;
        if (lat !== 1 || en_cycles !== 0) begin
            n_bad++;
            $display("FAIL amt0_timing lat=%0d en=%0d need 1/0", lat, en_cycles);
        end
        finish_rsp();
    endtask

    task automatic test_invalid_op;
        int lat; logic ok; logic stable;
        do_req(32'hDEAD_BEEF, 3'b100, 5'd9, lat, ok);
        n_cmp++;
        if (ok !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'hDEAD_BEEF || rsp_carry !== 1'b0) begin
            n_bad++;
            $display("FAIL badop_rsp err=%b got=%h c=%b need 1 deadbeef 0", rsp_err, rsp_data, rsp_carry);
        end
        n_cmp++;
        if (lat !== 1 || en_cycles !== 0) begin
            n_bad++;
            $display("FAIL badop_timing lat=%0d en=%0d need 1/0", lat, en_cycles);
        end
        stable = 1'b1;
        req_valid = 1'b1;
        repeat (5) begin
            @(negedge clk2);
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'hDEAD_BEEF || req_ready !== 1'b0) stable = 1'b0;
        end
        req_valid = 1'b0;
        n_cmp++;
        if (stable !== 1'b1) begin
            n_bad++;
            $display("FAIL badop_hold stable=%b need 1 (v=%b e=%b d=%h rdy=%b)", stable, rsp_valid, rsp_err, rsp_data, req_ready);
        end
        finish_rsp();
    endtask

    task automatic test_reset_mid;
        int lat; logic ok; logic saw;
        @(negedge clk2);
        req_valid = 1'b1; req_data = $urandom; req_op = 3'b010; req_amt = 5'd14; rsp_ready = 1'b0;
        for (int i = 0; i < 40 && !req_ready; i++) @(negedge clk2);
        @(posedge clk2);
        @(negedge clk2);
        req_valid = 1'b0;
        repeat (3) @(negedge clk2);
        n_cmp++;
        if (en_sh !== 1'b1 || sh_amt !== 3'd7 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_pass2 en=%b amt=%0d busy=%b need 1/7/1", en_sh, sh_amt, busy);
        end
        #1 rst2 = 1'b1;
        #1;
        n_cmp++;
        if ({en_sh, busy, req_ready, rsp_valid} !== 4'b0 || sh_in !== '0) begin
            n_bad++;
            $display("FAIL rstmid_drop got=%b sh_in=%h need 0000/0", {en_sh, busy, req_ready, rsp_valid}, sh_in);
        end
        @(negedge clk2);
        rst2 = 1'b0;
        saw = 1'b0;
        repeat (15) begin
            @(negedge clk2);
            if (rsp_valid !== 1'b0 || en_sh !== 1'b0) saw = 1'b1;
        end
        n_cmp++;
        if (saw !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_norsp saw=%b need 0", saw);
        end
        do_req(32'hF000_0000, 3'b010, 5'd4, lat, ok);
        n_cmp++;
        if (ok !== 1'b1 || rsp_data !== 32'h0F00_0000 || lat !== 4) begin
            n_bad++;
            $display("FAIL rstmid_next got=%h lat=%0d need 0f000000/4", rsp_data, lat);
        end
        finish_rsp();
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] da, db;
        int n;
        da = $urandom; db = $urandom;
        @(negedge clk2);
        rsp_ready = 1'b1; req_valid = 1'b1; req_data = da; req_op = 3'b010; req_amt = 5'd9;
        for (int i = 0; i < 40 && !req_ready; i++) @(negedge clk2);
        @(posedge clk2);
        @(negedge clk2);
        req_data = db; req_op = 3'b000; req_amt = 5'd3;
        n = 1;
        while (!rsp_valid && n < 100) begin @(negedge clk2); n++; end
        n_cmp++;
        if (rsp_valid !== 1'b1 || n !== 7 || rsp_data !== ideal(da, 3'b010, 9)) begin
            n_bad++;
            $display("FAIL b2b_first got=%h n=%0d need %h/7", rsp_data, n, ideal(da, 3'b010, 9));
        end
        @(negedge clk2);
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_gap v=%b rdy=%b busy=%b need 0/1/0", rsp_valid, req_ready, busy);
        end
        @(negedge clk2);
        req_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_accept busy=%b rdy=%b need 1/0", busy, req_ready);
        end
        n = 1;
        while (!rsp_valid && n < 100) begin @(negedge clk2); n++; end
        n_cmp++;
        if (rsp_valid !== 1'b1 || n !== 4 || rsp_data !== (db << 3)) begin
            n_bad++;
            $display("FAIL b2b_second got=%h n=%0d need %h/4", rsp_data, n, db << 3);
        end
        @(negedge clk2);
        rsp_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [4:0]   corner[8] = '{5'd0, 5'd1, 5'd6, 5'd7, 5'd8, 5'd14, 5'd15, 5'd31};
        logic [W-1:0] d, sd;
        logic [2:0]   op;
        logic [4:0]   amt;
        logic [W:0]   exp;
        logic         ok, seq_ok, stable;
        int           lat, np, exp_lat;
        for (int it = 0; it < 30; it++) begin
            d   = $urandom;
            op  = ($urandom_range(0, 7) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
            amt = ($urandom_range(0, 1) == 1) ? corner[$urandom_range(0, 7)] : 5'($urandom_range(0, 31));
            exp = ideal(d, op, int'(amt));
            np  = (op[2] || amt == 0) ? 0 : (int'(amt) + MS - 1) / MS;
            exp_lat = np * (SL + 1) + 1;
            do_req(d, op, amt, lat, ok);
            n_cmp++;
            if (ok !== 1'b1 || {rsp_carry, rsp_data} !== exp || rsp_err !== op[2]) begin
                n_bad++;
                $display("FAIL rand_rsp it=%0d op=%0d amt=%0d got=%b/%h e=%b need %b/%h e=%b",
                         it, op, amt, rsp_carry, rsp_data, rsp_err, exp[W], exp[W-1:0], op[2]);
            end
            n_cmp++;
            if (lat !== exp_lat || en_cycles !== np * SL) begin
                n_bad++;
                $display("FAIL rand_timing it=%0d amt=%0d lat=%0d en=%0d need %0d/%0d", it, amt, lat, en_cycles, exp_lat, np * SL);
            end
            seq_ok = (amt_seq.size() == np);
            for (int k = 0; k < np && seq_ok; k++)
                if (int'(amt_seq[k]) != ((k < np - 1) ? MS : int'(amt) - (np - 1) * MS)) seq_ok = 1'b0;
            n_cmp++;
            if (seq_ok !== 1'b1) begin
                n_bad++;
                $display("FAIL rand_passes it=%0d amt=%0d passes=%0d need %0d", it, amt, amt_seq.size(), np);
            end
            sd = rsp_data;
            stable = 1'b1;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk2);
                if (rsp_valid !== 1'b1 || rsp_data !== sd || req_ready !== 1'b0) stable = 1'b0;
            end
            n_cmp++;
            if (stable !== 1'b1) begin
                n_bad++;
                $display("FAIL rand_hold it=%0d v=%b d=%h need 1/%h", it, rsp_valid, rsp_data, sd);
            end
            finish_rsp();
        end
    endtask

    initial begin
        test_reset();
        test_lsl31();
        test_asr20();
        test_amt0();
        test_invalid_op();
        test_reset_mid();
        test_back_to_back();
        test_random();
        n_cmp++;
        if (viol !== 0 || stab_viol !== 0) begin
            n_bad++;
            $display("FAIL unit_protocol viol=%0d unstable=%0d need 0/0", viol, stab_viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
